// File: rtl/event_encoder8x3_if.sv
// Handshake and event bus for event_encoder8x3.
//   master : event source / consumer side (drives req_in, ready_in)
//   slave  : encoder side (drives code_out, valid_out, pending_out, drop_out)
// Signals:
//   req_in      [7:0] single-cycle event pulses, bit i requests index i
//   ready_in          consumer accepts code_out this cycle when valid_out=1
//   code_out    [2:0] index of the held event
//   valid_out         code_out holds a valid, unaccepted event
//   pending_out [7:0] pending set, excluding the index held in code_out
//   drop_out          one-cycle pulse: a request merged into an existing one
//
// valid/ready: a transfer happens on every rising clk edge where
// valid_out=1 and ready_in=1. Once valid_out rises, code_out and valid_out
// stay stable until that transfer; the encoder never retracts an event.
interface event_encoder8x3_if;
    logic [7:0] req_in;
    logic       ready_in;
    logic [2:0] code_out;
    logic       valid_out;
    logic [7:0] pending_out;
    logic       drop_out;

    modport master (
        output req_in,
        output ready_in,
        input  code_out,
        input  valid_out,
        input  pending_out,
        input  drop_out
    );

    modport slave (
        input  req_in,
        input  ready_in,
        output code_out,
        output valid_out,
        output pending_out,
        output drop_out
    );
endinterface

// File: rtl/event_encoder8x3.sv
// Sequential 8-to-3 event encoder. Single-cycle pulses on req_in are
// collected into a pending set and handed out one per transfer as a 3-bit
// index over valid/ready.
// Parameters:
//   ROUND_ROBIN : 0 = fixed priority (index 7 highest)
//                 1 = round-robin, scan starts after the last loaded index
// Ports:
//   clk   : clock, all state updates on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : event_encoder8x3_if.slave (req/ready in, code/valid/pending/drop out)
module event_encoder8x3 #(
    parameter bit ROUND_ROBIN = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    event_encoder8x3_if.slave         bus
);

    logic [7:0] r_pend;
    logic [2:0] r_code;
    logic       r_valid;
    logic       r_drop;
    logic [2:0] r_ptr;

    logic       w_load;
    logic [7:0] w_cand;
    logic [7:0] w_held_oh;
    logic [7:0] w_drop_vec;
    logic [2:0] w_sel;
    logic       w_found;

    // A new event may be loaded whenever the output slot is empty or being
    // accepted this cycle.
    assign w_load = !r_valid || bus.ready_in;
    assign w_cand = r_pend | bus.req_in;

    // One-hot of the index currently held on code_out (zero when idle).
    assign w_held_oh = r_valid ? (8'(1) << r_code) : 8'h00;

    // A request merges (drops) if its bit is already pending, or if it hits
    // the held index while that index is not being accepted. A re-request of
    // the index being accepted this cycle is a fresh event, not a drop.
    assign w_drop_vec = (bus.req_in & r_pend)
                      | (bus.ready_in ? 8'h00 : (bus.req_in & w_held_oh));

    always_comb begin
        w_sel   = 3'd0;
        w_found = 1'b0;
        if (ROUND_ROBIN) begin
            // Scan ptr+1, ptr+2, ... wrapping; i=8 lands back on ptr itself.
            for (int i = 1; i <= 8; i++) begin
                if (!w_found && w_cand[3'(r_ptr + 3'(i))]) begin
                    w_sel   = 3'(r_ptr + 3'(i));
                    w_found = 1'b1;
                end
            end
        end else begin
            // Ascending scan: the last set bit seen wins, i.e. the highest.
            for (int i = 0; i < 8; i++) begin
                if (w_cand[i]) begin
                    w_sel   = 3'(i);
                    w_found = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend  <= 8'h00;
            r_code  <= 3'd0;
            r_valid <= 1'b0;
            r_drop  <= 1'b0;
            r_ptr   <= 3'd7;
        end else begin
            r_drop <= |w_drop_vec;
            if (w_load) begin
                if (w_cand != 8'h00) begin
                    r_code  <= w_sel;
                    r_valid <= 1'b1;
                    r_pend  <= w_cand & ~(8'(1) << w_sel);
                    r_ptr   <= w_sel;
                end else begin
                    r_valid <= 1'b0;
                    r_pend  <= 8'h00;
                end
            end else begin
                // Output stalled: a request for the held index is merged into
                // it rather than queued again, so it is serviced only once.
                r_pend <= r_pend | (bus.req_in & ~w_held_oh);
            end
        end
    end

    assign bus.code_out    = r_code;
    assign bus.valid_out   = r_valid;
    assign bus.pending_out = r_pend;
    assign bus.drop_out    = r_drop;

endmodule
